// File: rtl/raifes_gpio_multi.sv
// Parametrised HASTI (AHB-Lite) GPIO slave: data/direction, synchronised inputs, set/clear/toggle.
// Optional per-pin edge interrupts are built when RAIFES_GPIO_IRQ_EN is defined.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

module raifes_gpio_multi #(
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hC0000000
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [WIDTH-1:0]               gpio_d,
  output logic [WIDTH-1:0]               gpio_en,
  input  logic [WIDTH-1:0]               gpio_i,
  output logic                           irq,
  input  logic [`HASTI_ADDR_WIDTH-1:0]   haddr,
  input  logic                           hwrite,
  input  logic [`HASTI_SIZE_WIDTH-1:0]   hsize,
  input  logic [`HASTI_BURST_WIDTH-1:0]  hburst,
  input  logic                           hmastlock,
  input  logic [`HASTI_PROT_WIDTH-1:0]   hprot,
  input  logic [`HASTI_TRANS_WIDTH-1:0]  htrans,
  input  logic [`HASTI_BUS_WIDTH-1:0]    hwdata,
  output logic [`HASTI_BUS_WIDTH-1:0]    hrdata,
  output logic                           hready,
  output logic [`HASTI_RESP_WIDTH-1:0]   hresp
);

  localparam logic [3:0] OFF_DOUT  = 4'h0;
  localparam logic [3:0] OFF_DIR   = 4'h1;
  localparam logic [3:0] OFF_DIN   = 4'h2;
  localparam logic [3:0] OFF_SET   = 4'h3;
  localparam logic [3:0] OFF_CLR   = 4'h4;
  localparam logic [3:0] OFF_TGL   = 4'h5;
  localparam logic [3:0] OFF_IEN   = 4'h6;
  localparam logic [3:0] OFF_IPEND = 4'h7;
  localparam logic [3:0] OFF_IEDGE = 4'h8;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                       r_state;
  logic [3:0]                   r_off;
  logic                         r_wr;
  logic [WIDTH-1:0]             r_dout;
  logic [WIDTH-1:0]             r_dir;
  logic [WIDTH-1:0]             r_sync1;
  logic [WIDTH-1:0]             r_sync2;
  logic [`HASTI_BUS_WIDTH-1:0]  r_hrdata;
  logic                         w_sel;
  logic                         w_wr_now;
  logic [WIDTH-1:0]             w_wdata;
  logic [`HASTI_BUS_WIDTH-1:0]  w_rdata;
  logic                         w_unused;

`ifdef RAIFES_GPIO_IRQ_EN
  logic [WIDTH-1:0]             r_sync3;
  logic [WIDTH-1:0]             r_irq_en;
  logic [WIDTH-1:0]             r_irq_pend;
  logic [WIDTH-1:0]             r_irq_edge;
  logic                         r_irq;
  logic [WIDTH-1:0]             w_edge;
  logic [WIDTH-1:0]             w_pend_clr;
`endif

  assign w_sel    = hready && htrans[1] && (haddr[31:6] == BASE_ADDR[31:6]);
  assign w_wr_now = (r_state == S_ACCESS) && r_wr;
  assign w_wdata  = hwdata[WIDTH-1:0];
  assign w_unused = ^{hsize, hburst, hmastlock, hprot, htrans, haddr, hwdata};

  assign hready  = (r_state == S_IDLE);
  assign hresp   = '0;
  assign hrdata  = r_hrdata;
  assign gpio_d  = r_dout;
  assign gpio_en = r_dir;

`ifdef RAIFES_GPIO_IRQ_EN
  // Per-pin edge select: IRQ_EDGE=0 picks rising, 1 picks falling.
  assign w_edge     = (~r_irq_edge & r_sync2 & ~r_sync3) | (r_irq_edge & ~r_sync2 & r_sync3);
  assign w_pend_clr = (w_wr_now && r_off == OFF_IPEND) ? w_wdata : '0;
  assign irq        = r_irq;
`else
  assign irq        = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (r_off)
      OFF_DOUT, OFF_SET, OFF_CLR, OFF_TGL: w_rdata[WIDTH-1:0] = r_dout;
      OFF_DIR:   w_rdata[WIDTH-1:0] = r_dir;
      OFF_DIN:   w_rdata[WIDTH-1:0] = r_sync2;
`ifdef RAIFES_GPIO_IRQ_EN
      OFF_IEN:   w_rdata[WIDTH-1:0] = r_irq_en;
      OFF_IPEND: w_rdata[WIDTH-1:0] = r_irq_pend;
      OFF_IEDGE: w_rdata[WIDTH-1:0] = r_irq_edge;
`endif
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_off    <= '0;
      r_wr     <= 1'b0;
      r_dout   <= '0;
      r_dir    <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_hrdata <= '0;
`ifdef RAIFES_GPIO_IRQ_EN
      r_sync3    <= '0;
      r_irq_en   <= '0;
      r_irq_pend <= '0;
      r_irq_edge <= '0;
      r_irq      <= 1'b0;
`endif
    end else begin
      r_sync1 <= gpio_i;
      r_sync2 <= r_sync1;
`ifdef RAIFES_GPIO_IRQ_EN
      r_sync3    <= r_sync2;
      // Edge set is OR'd after the W1C mask so a coincident edge wins.
      r_irq_pend <= (r_irq_pend & ~w_pend_clr) | w_edge;
      r_irq      <= |(r_irq_pend & r_irq_en);
`endif
      case (r_state)
        S_IDLE: begin
          if (w_sel) begin
            r_off   <= haddr[5:2];
            r_wr    <= hwrite;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_state <= S_IDLE;
          if (r_wr) begin
            case (r_off)
              OFF_DOUT:  r_dout     <= w_wdata;
              OFF_DIR:   r_dir      <= w_wdata;
              OFF_SET:   r_dout     <= r_dout | w_wdata;
              OFF_CLR:   r_dout     <= r_dout & ~w_wdata;
              OFF_TGL:   r_dout     <= r_dout ^ w_wdata;
`ifdef RAIFES_GPIO_IRQ_EN
              OFF_IEN:   r_irq_en   <= w_wdata;
              OFF_IEDGE: r_irq_edge <= w_wdata;
`endif
              default: ;
            endcase
          end else begin
            r_hrdata <= w_rdata;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raifes_gpio_multi.sv
// Scoreboarded bench for raifes_gpio_multi: directed bus transfers queue their expected
// completion values; a negedge monitor compares them when hready returns high.
module tb_raifes_gpio_multi;

  localparam logic [31:0] BASE = 32'hC0000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  gpio_d, gpio_en, gpio_i;
  logic        irq;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = '0;
  logic        hmastlock = 1'b0;
  logic [3:0]  hprot = '0;
  logic [1:0]  htrans = '0;
  logic [31:0] hwdata = '0;
  logic [31:0] hrdata;
  logic        hready;
  logic [0:0]  hresp;

  raifes_gpio_multi #(.WIDTH(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .gpio_d(gpio_d), .gpio_en(gpio_en), .gpio_i(gpio_i), .irq(irq),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
    .hprot(hprot), .htrans(htrans), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    logic [7:0]  d;
    logic [7:0]  en;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic        prev_hr = 1'b1;
  logic [7:0]  cur_d = '0;
  logic [7:0]  cur_en = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !prev_hr && hready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_completion", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (e.rd) chk("hrdata", hrdata, e.data);
        chk("gpio_d", {24'd0, gpio_d}, {24'd0, e.d});
        chk("gpio_en", {24'd0, gpio_en}, {24'd0, e.en});
        chk("hresp", {31'd0, hresp}, 32'd0);
      end
    end
    prev_hr = hready;
  end

  task automatic xfer(input bit wr, input logic [7:0] off, input logic [31:0] wd, input logic [31:0] exp_rd);
    exp_t e;
    e.rd = !wr; e.data = exp_rd; e.d = cur_d; e.en = cur_en;
    sbq.push_back(e);
    haddr = BASE | {24'd0, off}; hwrite = wr; htrans = 2'b10;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = wd;
    chk("hready_wait", {31'd0, hready}, 32'd0);
    @(posedge clk); #1;
    chk("hready_done", {31'd0, hready}, 32'd1);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic [7:0] nd, input logic [7:0] nen);
    cur_d = nd; cur_en = nen;
    xfer(1'b1, off, wd, 32'd0);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp);
    xfer(1'b0, off, 32'd0, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    gpio_i = '0;
    cycles(3);
    reset = 1'b0;
    chk("rst_hready", {31'd0, hready}, 32'd1);
    chk("rst_hresp", {31'd0, hresp}, 32'd0);
    chk("rst_gpio_d", {24'd0, gpio_d}, 32'd0);
    chk("rst_gpio_en", {24'd0, gpio_en}, 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    mon_en = 1'b1;

    rd(8'h00, 32'h0);
    rd(8'h04, 32'h0);
    rd(8'h08, 32'h0);

    wr(8'h00, 32'hA5, 8'hA5, 8'h00);
    wr(8'h04, 32'hFF, 8'hA5, 8'hFF);
    rd(8'h00, 32'hA5);

    wr(8'h0C, 32'h0F, 8'hAF, 8'hFF);
    wr(8'h10, 32'h81, 8'h2E, 8'hFF);
    wr(8'h14, 32'hFF, 8'hD1, 8'hFF);
    rd(8'h0C, 32'hD1);
    rd(8'h10, 32'hD1);

    wr(8'h00, 32'hFFFFFFFF, 8'hFF, 8'hFF);
    rd(8'h00, 32'h000000FF);
    rd(8'h30, 32'h0);
    wr(8'h30, 32'h0, 8'hFF, 8'hFF);
    rd(8'h00, 32'h000000FF);

    // Unselected transfers: IDLE htrans at a valid address, and NONSEQ outside the window.
    haddr = BASE; hwrite = 1'b1; htrans = 2'b00; hwdata = 32'h0;
    cycles(1);
    chk("idle_htrans_hready", {31'd0, hready}, 32'd1);
    haddr = 32'hD0000000; htrans = 2'b10;
    cycles(1);
    chk("foreign_addr_hready", {31'd0, hready}, 32'd1);
    htrans = 2'b00;
    cycles(1);
    chk("unsel_gpio_d", {24'd0, gpio_d}, 32'hFF);

    gpio_i = 8'h3C;
    cycles(3);
    rd(8'h08, 32'h3C);

`ifdef RAIFES_GPIO_IRQ_EN
    wr(8'h18, 32'h01, 8'hFF, 8'hFF);
    wr(8'h20, 32'h00, 8'hFF, 8'hFF);
    wr(8'h1C, 32'hFF, 8'hFF, 8'hFF);
    rd(8'h1C, 32'h0);
    chk("irq_idle", {31'd0, irq}, 32'd0);
    gpio_i = 8'h3D;
    cycles(1); chk("irq_rise_k",  {31'd0, irq}, 32'd0);
    cycles(2); chk("irq_rise_k2", {31'd0, irq}, 32'd0);
    cycles(1); chk("irq_rise_k3", {31'd0, irq}, 32'd1);
    rd(8'h1C, 32'h01);
    wr(8'h1C, 32'h01, 8'hFF, 8'hFF);
    chk("irq_before_drop", {31'd0, irq}, 32'd1);
    cycles(1); chk("irq_cleared_rise", {31'd0, irq}, 32'd0);
    rd(8'h1C, 32'h0);

    wr(8'h20, 32'h01, 8'hFF, 8'hFF);
    rd(8'h20, 32'h01);
    gpio_i = 8'h3C;
    cycles(3); chk("irq_fall_k2", {31'd0, irq}, 32'd0);
    cycles(1); chk("irq_fall_k3", {31'd0, irq}, 32'd1);
    rd(8'h1C, 32'h01);
    wr(8'h1C, 32'h01, 8'hFF, 8'hFF);
    cycles(1); chk("irq_cleared_fall", {31'd0, irq}, 32'd0);
`else
    wr(8'h18, 32'hFF, 8'hFF, 8'hFF);
    rd(8'h18, 32'h0);
    rd(8'h1C, 32'h0);
    gpio_i = 8'h3D;
    cycles(5);
    chk("irq_tied_low", {31'd0, irq}, 32'd0);
    gpio_i = 8'h3C;
    cycles(3);
`endif

    // Reset during ACCESS of a write of 0x55 to DATA_OUT aborts it.
    begin
      exp_t e;
      e.rd = 1'b0; e.data = '0; e.d = 8'h00; e.en = 8'h00;
      sbq.push_back(e);
      cur_d = 8'h00; cur_en = 8'h00;
      haddr = BASE; hwrite = 1'b1; htrans = 2'b10;
      @(posedge clk); #1;
      htrans = 2'b00; hwdata = 32'h55; reset = 1'b1;
      chk("abort_hready_wait", {31'd0, hready}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_hready", {31'd0, hready}, 32'd1);
      chk("abort_gpio_d", {24'd0, gpio_d}, 32'd0);
    end
    rd(8'h00, 32'h0);
    wr(8'h00, 32'h3, 8'h03, 8'h00);
    rd(8'h00, 32'h3);

    cycles(2);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
